// File: rtl/matmul_ctrl_pkg.sv
// Shared types and constants for the matmul_ctrl sequencer.
// Word addressing is byte-based with 4-byte words.
package matmul_ctrl_pkg;

    localparam int DATA_W     = 32;
    localparam int WORD_SHIFT = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_MAC   = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Byte address of element number idx in a row-major array at base.
    function automatic logic [DATA_W-1:0] elem_addr(
        input logic [DATA_W-1:0] base,
        input logic [DATA_W-1:0] idx
    );
        return base + (idx << WORD_SHIFT);
    endfunction

endpackage

// File: rtl/matmul_ctrl_addrgen.sv
// Combinational address generator for the A, B and C element addresses.
// All products and sums wrap modulo 2^32.
module matmul_addrgen
    import matmul_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] i_idx_i,
    input  logic [DATA_W-1:0] i_idx_j,
    input  logic [DATA_W-1:0] i_idx_k,
    input  logic [DATA_W-1:0] i_num_k,
    input  logic [DATA_W-1:0] i_num_j,
    input  logic [DATA_W-1:0] i_base_a,
    input  logic [DATA_W-1:0] i_base_b,
    input  logic [DATA_W-1:0] i_base_c,
    output logic [DATA_W-1:0] o_addr_a,
    output logic [DATA_W-1:0] o_addr_b,
    output logic [DATA_W-1:0] o_addr_c
);

    logic [DATA_W-1:0] w_lin_a;
    logic [DATA_W-1:0] w_lin_b;
    logic [DATA_W-1:0] w_lin_c;

    assign w_lin_a = i_idx_i * i_num_k + i_idx_k;
    assign w_lin_b = i_idx_k * i_num_j + i_idx_j;
    assign w_lin_c = i_idx_i * i_num_j + i_idx_j;

    assign o_addr_a = elem_addr(i_base_a, w_lin_a);
    assign o_addr_b = elem_addr(i_base_b, w_lin_b);
    assign o_addr_c = elem_addr(i_base_c, w_lin_c);

endmodule

// File: rtl/matmul_ctrl.sv
// Sequencer for C = A x B over a single-cycle-latency read port and a write port.
// Loop order i, j, k; one READ/MAC pair per product term, one WRITE per C element.
module matmul_ctrl
    import matmul_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] num_i,
    input  logic [DATA_W-1:0] num_k,
    input  logic [DATA_W-1:0] num_j,
    input  logic [DATA_W-1:0] addrM1,
    input  logic [DATA_W-1:0] addrM2,
    input  logic [DATA_W-1:0] addrM3,
    output logic [DATA_W-1:0] addr_a,
    output logic [DATA_W-1:0] addr_b,
    input  logic [DATA_W-1:0] rd_a,
    input  logic [DATA_W-1:0] rd_b,
    output logic [DATA_W-1:0] addr_c,
    output logic [DATA_W-1:0] wd,
    output logic              we,
    output logic [DATA_W-1:0] i,
    output logic [DATA_W-1:0] j,
    output logic [DATA_W-1:0] k,
    output logic              busy,
    output logic              done
);

    state_t r_state;
    state_t w_state_nxt;

    logic [DATA_W-1:0] r_i;
    logic [DATA_W-1:0] r_j;
    logic [DATA_W-1:0] r_k;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_num_i;
    logic [DATA_W-1:0] r_num_k;
    logic [DATA_W-1:0] r_num_j;
    logic [DATA_W-1:0] r_base_a;
    logic [DATA_W-1:0] r_base_b;
    logic [DATA_W-1:0] r_base_c;
    logic [DATA_W-1:0] r_addr_a_hold;
    logic [DATA_W-1:0] r_addr_b_hold;

    logic [DATA_W-1:0] w_addr_a;
    logic [DATA_W-1:0] w_addr_b;
    logic [DATA_W-1:0] w_addr_c;
    logic [DATA_W-1:0] w_prod;
    logic              w_zero_shape;
    logic              w_last_i;
    logic              w_last_j;
    logic              w_last_k;

    matmul_addrgen u_addrgen (
        .i_idx_i  (r_i),
        .i_idx_j  (r_j),
        .i_idx_k  (r_k),
        .i_num_k  (r_num_k),
        .i_num_j  (r_num_j),
        .i_base_a (r_base_a),
        .i_base_b (r_base_b),
        .i_base_c (r_base_c),
        .o_addr_a (w_addr_a),
        .o_addr_b (w_addr_b),
        .o_addr_c (w_addr_c)
    );

    // Shapes are checked on the live inputs because they are latched on the same edge.
    assign w_zero_shape = (num_i == '0) || (num_k == '0) || (num_j == '0);
    assign w_last_i     = (r_i == r_num_i - 1'b1);
    assign w_last_j     = (r_j == r_num_j - 1'b1);
    assign w_last_k     = (r_k == r_num_k - 1'b1);
    assign w_prod       = rd_a * rd_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = w_zero_shape ? ST_DONE : ST_READ;
                end
            end
            ST_READ:  w_state_nxt = ST_MAC;
            ST_MAC:   w_state_nxt = w_last_k ? ST_WRITE : ST_READ;
            ST_WRITE: w_state_nxt = (w_last_j && w_last_i) ? ST_DONE : ST_READ;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_i           <= '0;
            r_j           <= '0;
            r_k           <= '0;
            r_acc         <= '0;
            r_num_i       <= '0;
            r_num_k       <= '0;
            r_num_j       <= '0;
            r_base_a      <= '0;
            r_base_b      <= '0;
            r_base_c      <= '0;
            r_addr_a_hold <= '0;
            r_addr_b_hold <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_num_i  <= num_i;
                        r_num_k  <= num_k;
                        r_num_j  <= num_j;
                        r_base_a <= addrM1;
                        r_base_b <= addrM2;
                        r_base_c <= addrM3;
                        r_i      <= '0;
                        r_j      <= '0;
                        r_k      <= '0;
                        r_acc    <= '0;
                    end
                end
                ST_READ: begin
                    r_addr_a_hold <= w_addr_a;
                    r_addr_b_hold <= w_addr_b;
                end
                ST_MAC: begin
                    r_acc <= (r_k == '0) ? w_prod : r_acc + w_prod;
                    if (!w_last_k) begin
                        r_k <= r_k + 1'b1;
                    end
                end
                ST_WRITE: begin
                    r_k <= '0;
                    if (!w_last_j) begin
                        r_j <= r_j + 1'b1;
                    end else begin
                        r_j <= '0;
                        if (!w_last_i) begin
                            r_i <= r_i + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Read addresses are live in READ and frozen at their last value elsewhere.
    assign addr_a = (r_state == ST_READ) ? w_addr_a : r_addr_a_hold;
    assign addr_b = (r_state == ST_READ) ? w_addr_b : r_addr_b_hold;
    assign addr_c = (r_state == ST_WRITE) ? w_addr_c : '0;
    assign wd     = r_acc;
    assign we     = (r_state == ST_WRITE);
    assign busy   = (r_state != ST_IDLE);
    assign done   = (r_state == ST_DONE);
    assign i      = r_i;
    assign j      = r_j;
    assign k      = r_k;

endmodule

// File: tb/tb_matmul_ctrl.sv
// Self-checking bench for matmul_ctrl: memory model, write scoreboard, latency and reset checks.
module tb_matmul_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] num_i, num_k, num_j;
    logic [31:0] addrM1, addrM2, addrM3;
    logic [31:0] addr_a, addr_b, rd_a, rd_b, addr_c, wd;
    logic        we, busy, done;
    logic [31:0] idx_i, idx_j, idx_k;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_a [64];
    logic [31:0] mem_b [64];
    logic [31:0] base_a, base_b, base_c;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    always #5 clk = ~clk;

    matmul_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .num_i  (num_i),
        .num_k  (num_k),
        .num_j  (num_j),
        .addrM1 (addrM1),
        .addrM2 (addrM2),
        .addrM3 (addrM3),
        .addr_a (addr_a),
        .addr_b (addr_b),
        .rd_a   (rd_a),
        .rd_b   (rd_b),
        .addr_c (addr_c),
        .wd     (wd),
        .we     (we),
        .i      (idx_i),
        .j      (idx_j),
        .k      (idx_k),
        .busy   (busy),
        .done   (done)
    );

    // Read port: data for the address seen at an edge is valid in the following cycle.
    logic [31:0] off_a, off_b;
    assign off_a = (addr_a - base_a) >> 2;
    assign off_b = (addr_b - base_b) >> 2;
    always @(posedge clk) begin
        rd_a <= mem_a[off_a[5:0]];
        rd_b <= mem_b[off_b[5:0]];
    end

    task automatic push(input logic [31:0] addr, input logic [31:0] data);
        wr_t e;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic push_model(input int ni, input int nk, input int nj);
        logic [31:0] acc;
        for (int ii = 0; ii < ni; ii++) begin
            for (int jj = 0; jj < nj; jj++) begin
                acc = '0;
                for (int kk = 0; kk < nk; kk++) acc += mem_a[ii*nk+kk] * mem_b[kk*nj+jj];
                push(base_c + 32'((ii*nj + jj) * 4), acc);
            end
        end
    endtask

    task automatic fill_random();
        for (int n = 0; n < 64; n++) begin
            mem_a[n] = $urandom_range(0, 1000);
            mem_b[n] = $urandom_range(0, 1000);
        end
    endtask

    // Runs one job; abort_at > 0 asserts reset at that cycle and expects abort_left writes unserviced.
    task automatic run_job(input int ni, input int nk, input int nj, input int exp_lat,
                           input bit hold_start, input int abort_at, input int abort_left);
        int done_cnt;
        int done_cyc;
        wr_t e;
        done_cnt = 0;
        done_cyc = 0;
        @(negedge clk);
        num_i = ni; num_k = nk; num_j = nj;
        addrM1 = base_a; addrM2 = base_b; addrM3 = base_c;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_start) start = 1'b0;
        num_i = $urandom; num_k = $urandom; num_j = $urandom;
        addrM1 = $urandom; addrM2 = $urandom; addrM3 = $urandom;
        for (int c = 1; c <= exp_lat + 3; c++) begin
            @(negedge clk);
            if (we) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write cycle %0d addr %h data %h", c, addr_c, wd);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (addr_c !== e.addr || wd !== e.data) begin
                        errors++;
                        $display("FAIL write cycle %0d got addr %h data %h want addr %h data %h",
                                 c, addr_c, wd, e.addr, e.data);
                    end
                end
            end
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
                if (hold_start) start = 1'b0;
            end
            checks++;
            if (busy !== (c <= exp_lat)) begin
                errors++;
                $display("FAIL busy cycle %0d got %b want %b", c, busy, (c <= exp_lat));
            end
            if (abort_at != 0 && c == abort_at) begin
                reset = 1'b1;
                break;
            end
        end
        if (abort_at != 0) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                checks++;
                if ({addr_a, addr_b, addr_c, wd, idx_i, idx_j, idx_k, we, busy, done} !== '0) begin
                    errors++;
                    $display("FAIL abort_outputs cycle %0d we %b done %b busy %b wd %h addr_c %h addr_a %h",
                             c, we, done, busy, wd, addr_c, addr_a);
                end
            end
            reset = 1'b0;
            checks++;
            if (exp_q.size() != abort_left) begin
                errors++;
                $display("FAIL abort_pending got %0d want %0d", exp_q.size(), abort_left);
            end
            exp_q.delete();
        end else begin
            checks++;
            if (done_cnt != 1) begin
                errors++;
                $display("FAIL done_count got %0d want 1", done_cnt);
            end
            checks++;
            if (done_cyc != exp_lat) begin
                errors++;
                $display("FAIL latency got %0d want %0d", done_cyc, exp_lat);
            end
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL missing_writes got %0d pending want 0", exp_q.size());
                exp_q.delete();
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        num_i = 2; num_k = 2; num_j = 2;
        addrM1 = 32'h100; addrM2 = 32'h200; addrM3 = 32'h300;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({addr_a, addr_b, addr_c, wd, idx_i, idx_j, idx_k, we, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs busy %b we %b done %b wd %h addr_a %h", busy, we, done, wd, addr_a);
        end
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_over_start busy %b want 0", busy);
        end
    endtask

    task automatic test_1x1x1();
        base_a = 32'h100; base_b = 32'h200; base_c = 32'h300;
        mem_a[0] = 3; mem_b[0] = 5;
        push(32'h300, 32'd15);
        run_job(1, 1, 1, 4, 1'b0, 0, 0);
    endtask

    task automatic load_2x2x2();
        mem_a[0] = 1; mem_a[1] = 2; mem_a[2] = 3; mem_a[3] = 4;
        mem_b[0] = 5; mem_b[1] = 6; mem_b[2] = 7; mem_b[3] = 8;
        push(base_c + 0,  32'd19);
        push(base_c + 4,  32'd22);
        push(base_c + 8,  32'd43);
        push(base_c + 12, 32'd50);
    endtask

    task automatic test_2x2x2();
        base_a = 32'h1000; base_b = 32'h2000; base_c = 32'h3000;
        load_2x2x2();
        run_job(2, 2, 2, 21, 1'b0, 0, 0);
    endtask

    task automatic test_zero_shape();
        run_job(2, 0, 2, 1, 1'b0, 0, 0);
        run_job(0, 3, 3, 1, 1'b0, 0, 0);
    endtask

    task automatic test_overflow();
        base_a = 32'h40; base_b = 32'h80; base_c = 32'hC0;
        mem_a[0] = 32'h10000; mem_b[0] = 32'h10000;
        push(32'hC0, 32'd0);
        run_job(1, 1, 1, 4, 1'b0, 0, 0);
    endtask

    task automatic test_reset_mid();
        base_a = 32'h1000; base_b = 32'h2000; base_c = 32'h3000;
        load_2x2x2();
        run_job(2, 2, 2, 21, 1'b0, 7, 3);
        load_2x2x2();
        run_job(2, 2, 2, 21, 1'b0, 0, 0);
    endtask

    task automatic test_back_to_back();
        base_a = 32'h500; base_b = 32'h600; base_c = 32'h700;
        fill_random();
        push_model(2, 1, 3);
        run_job(2, 1, 3, 19, 1'b1, 0, 0);
    endtask

    task automatic test_random_shape();
        base_a = 32'hFFFF_FF00; base_b = 32'h0; base_c = 32'h8000_0000;
        fill_random();
        push_model(3, 2, 4);
        run_job(3, 2, 4, 61, 1'b0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        num_i = '0; num_k = '0; num_j = '0;
        addrM1 = '0; addrM2 = '0; addrM3 = '0;
        base_a = '0; base_b = '0; base_c = '0;
        for (int n = 0; n < 64; n++) begin
            mem_a[n] = '0;
            mem_b[n] = '0;
        end
        test_reset();
        test_1x1x1();
        test_2x2x2();
        test_zero_shape();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        test_random_shape();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matmul_ctrl.md
MATMUL_CTRL -- requirements
Module: matmul_ctrl

Interface
REQ-001 SHALL have parameter none; all widths fixed at 32 bits, word size 4 bytes.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to run one C = A x B; sampled only in IDLE.
REQ-005 num_i, num_k, num_j  input  32 each  shapes: A is num_i x num_k, B is num_k x num_j, C is num_i x num_j (unsigned).
REQ-006 addrM1, addrM2, addrM3  input  32 each  byte base addresses of A, B, C (row-major).
REQ-007 addr_a, addr_b  output  32 each  read addresses for A[i][k], B[k][j].
REQ-008 rd_a, rd_b  input  32 each  read data, valid the cycle after the address is driven.
REQ-009 addr_c  output  32  write address C[i][j].
REQ-010 wd  output  32  write data.
REQ-011 we  output  1  write strobe, one cycle per C element.
REQ-012 i, j, k  output  32 each  current loop indices.
REQ-013 busy  output  1  high from start acceptance until the DONE cycle inclusive.
REQ-014 done  output  1  single-cycle completion pulse.

Function
REQ-015 FSM states SHALL be IDLE, READ, MAC, WRITE, DONE.
REQ-016 IDLE with start=1 SHALL latch shapes and bases, clear i/j/k and accumulator, go to DONE if any shape is 0, else READ.
REQ-017 Loop order SHALL be i outer, j middle, k innermost.
REQ-018 READ SHALL drive addr_a = addrM1 + ((i*num_k + k) << 2) and addr_b = addrM2 + ((k*num_j + j) << 2), all arithmetic mod 2^32, then go to MAC.
REQ-019 MAC SHALL set acc = rd_a*rd_b when k==0, else acc = acc + rd_a*rd_b (unsigned, low 32 bits kept, wraps silently).
REQ-020 MAC SHALL go to WRITE if k==num_k-1, else increment k and go to READ.
REQ-021 WRITE SHALL assert we=1 for exactly one cycle with addr_c = addrM3 + ((i*num_j + j) << 2) and wd = acc.
REQ-022 After WRITE: k<=0; if j<num_j-1 then j++ and go to READ; else j<=0, and if i<num_i-1 then i++ and go to READ, else go to DONE.
REQ-023 DONE SHALL assert done=1 for one cycle, then return to IDLE.
REQ-024 Latency SHALL be exactly 1 + num_i*num_j*(2*num_k+1) cycles from the start-sampling edge to done high; 1 cycle for any zero shape.
REQ-025 start while not IDLE (including DONE) SHALL be ignored; shape and base input changes while busy SHALL have no effect.
REQ-026 we SHALL be 0 in every state except WRITE; addr_a/addr_b SHALL hold their last value outside READ.

Reset
REQ-027 reset SHALL force IDLE; i, j, k, acc, addr_a, addr_b, addr_c, wd = 0; we, busy, done = 0.
REQ-028 reset mid-operation SHALL abort with no further we pulse and no done pulse; reset overrides start in the same cycle.

Structure
REQ-029 Shared package SHALL hold the state enum and constant WORD_SHIFT = 2.
REQ-030 Address arithmetic SHALL be one sub-module matmul_addrgen (i, j, k, shapes, bases -> addr_a, addr_b, addr_c), purely combinational.

Verification
REQ-031 1x1x1, A=[3], B=[5], start at edge 0 -> single we with wd=15, addr_c=addrM3; done at edge 4.
REQ-032 2x2x2, A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> writes 19, 22, 43, 50 in that order at C+0, +4, +8, +12; done after 21 cycles.
REQ-033 num_k=0 with num_i=num_j=2 -> no we, done exactly 1 cycle after start.
REQ-034 Overflow: A=[0x10000], B=[0x10000], 1x1x1 -> wd=0.
REQ-035 reset asserted in 3rd MAC of 2x2x2 -> no we or done afterward, all outputs 0; new start then runs full 21-cycle sequence correctly.
REQ-036 start pulsed every cycle during a 2x3x1 run -> exactly 6 writes and one done, with no restart until IDLE.
